// File: rtl/dmem_arbiter.sv
// Shared data-memory arbiter: grants the CPU MEM stage or the DMA port one access
// at a time, inserts WAIT_STATES wait cycles and stalls the pipeline until the CPU completes.
module dmem_arbiter #(
  parameter int WAIT_STATES  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ack,
  output logic        cpu_stall,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic [31:0] dma_rdata,
  output logic        dma_ack,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int CW = (WAIT_STATES < 1) ? 1 : $clog2(WAIT_STATES + 1);
  localparam logic [0:0]    S_IDLE     = 1'b0;
  localparam logic [0:0]    S_ACCESS   = 1'b1;
  localparam logic [CW-1:0] CNT_INIT   = CW'(WAIT_STATES);
  localparam logic [CW-1:0] CNT_ZERO   = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [3:0]    STARVE_LIM = 4'(STARVE_LIMIT);
  localparam logic [3:0]    STARVE_MAX = 4'd15;

  logic [0:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          owner_q, owner_d;   // 1 = DMA owns the current access
  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    starve_q, starve_d;
  logic [31:0]   cpu_hold_q, cpu_hold_d;
  logic [31:0]   dma_hold_q, dma_hold_d;
  logic          final_s;
  logic          dma_wins_s;

  assign final_s    = (state_q == S_ACCESS) && (cnt_q == CNT_ZERO);
  assign dma_wins_s = dma_req && (!cpu_req || (starve_q >= STARVE_LIM));

  // Next-state logic: arbitration in IDLE, wait-state countdown in ACCESS.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    owner_d    = owner_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    starve_d   = starve_q;
    cpu_hold_d = cpu_hold_q;
    dma_hold_d = dma_hold_q;
    case (state_q)
      S_IDLE: begin
        if (cpu_req || dma_req) begin
          state_d = S_ACCESS;
          cnt_d   = CNT_INIT;
          owner_d = dma_wins_s;
          we_d    = dma_wins_s ? dma_we    : cpu_we;
          addr_d  = dma_wins_s ? dma_addr  : cpu_addr;
          wdata_d = dma_wins_s ? dma_wdata : cpu_wdata;
        end else begin
          state_d = S_IDLE;
        end
        // Starvation count only moves while DMA is actually waiting on a CPU win.
        if (!dma_req || dma_wins_s) begin
          starve_d = 4'd0;
        end else if (starve_q != STARVE_MAX) begin
          starve_d = starve_q + 4'd1;
        end else begin
          starve_d = starve_q;
        end
      end
      S_ACCESS: begin
        if (cnt_q != CNT_ZERO) begin
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          state_d = S_IDLE;
          if (!we_q && owner_q) begin
            dma_hold_d = mem_rdata;
          end else if (!we_q) begin
            cpu_hold_d = mem_rdata;
          end else begin
            dma_hold_d = dma_hold_q;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and latched-request registers; reset aborts any access in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= CNT_ZERO;
      owner_q    <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      starve_q   <= 4'd0;
      cpu_hold_q <= 32'd0;
      dma_hold_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      owner_q    <= owner_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      starve_q   <= starve_d;
      cpu_hold_q <= cpu_hold_d;
      dma_hold_q <= dma_hold_d;
    end
  end

  // Outputs decoded from registered state; read data bypasses on the ack cycle.
  always_comb begin
    cpu_ack   = final_s && !owner_q;
    dma_ack   = final_s && owner_q;
    mem_we    = final_s && we_q;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    cpu_stall = cpu_req && !cpu_ack;
    if (cpu_ack && !we_q) begin
      cpu_rdata = mem_rdata;
    end else begin
      cpu_rdata = cpu_hold_q;
    end
    if (dma_ack && !we_q) begin
      dma_rdata = mem_rdata;
    end else begin
      dma_rdata = dma_hold_q;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small memory model and an
// expected-completion scoreboard checked on every ack.
module tb_dmem_arbiter;

  localparam int WS = 1;
  localparam int SL = 2;

  typedef struct packed {
    logic        is_dma;
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, cpu_ack, cpu_stall;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        dma_req, dma_we, dma_ack;
  logic [31:0] dma_addr, dma_wdata, dma_rdata;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic [31:0] mem [0:255];
  logic        pl_en = 1'b0;
  logic [7:0]  pl_addr = 8'd0;
  logic [31:0] pl_data = 32'd0;
  int          we_pulses = 0;

  exp_t sb_q[$];
  logic stall_hist [0:31];
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.WAIT_STATES(WS), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_ack(dma_ack),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  assign mem_rdata = mem[mem_addr[9:2]];

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr[9:2]] <= mem_wdata;
      we_pulses <= we_pulses + 1;
    end else if (pl_en) begin
      mem[pl_addr] <= pl_data;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    pl_addr = a[9:2];
    pl_data = d;
    pl_en   = 1'b1;
    @(posedge clk); #1;
    pl_en   = 1'b0;
  endtask

  // Waits for the next ack, compares it against the scoreboard head, returns cycles waited.
  task automatic wait_ack(input int budget, output int lat);
    exp_t e;
    logic found;
    found = 1'b0;
    lat = -1;
    for (int c = 0; c < budget && !found; c++) begin
      @(negedge clk);
      stall_hist[c] = cpu_stall;
      if (cpu_ack || dma_ack) begin
        found = 1'b1;
        lat = c;
        check("sb_empty_on_ack", {31'd0, (sb_q.size() == 0)}, 32'd0);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          check("ack_owner_dma", {31'd0, dma_ack}, {31'd0, e.is_dma});
          check("ack_owner_cpu", {31'd0, cpu_ack}, {31'd0, !e.is_dma});
          check("ack_mem_we", {31'd0, mem_we}, {31'd0, e.we});
          check("ack_mem_addr", mem_addr, e.addr);
          if (e.we) check("ack_mem_wdata", mem_wdata, e.data);
          else if (e.is_dma) check("dma_rdata", dma_rdata, e.data);
          else check("cpu_rdata", cpu_rdata, e.data);
        end
      end else begin
        check("mem_we_not_final", {31'd0, mem_we}, 32'd0);
      end
    end
    check("ack_seen", {31'd0, found}, 32'd1);
  endtask

  initial begin
    int lat;
    int base;
    exp_t e;
    rst = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'd0; cpu_wdata = 32'd0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = 32'd0; dma_wdata = 32'd0;
    @(posedge clk); #1;
    preload(32'h10, 32'hDEADBEEF);
    preload(32'h40, 32'hA0A0A0A0);
    preload(32'h44, 32'hB4B4B4B4);
    preload(32'h50, 32'h55AA55AA);
    preload(32'h70, 32'h11111111);

    // Reset values
    @(negedge clk);
    check("rst_cpu_ack", {31'd0, cpu_ack}, 32'd0);
    check("rst_dma_ack", {31'd0, dma_ack}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_cpu_rdata", cpu_rdata, 32'd0);
    check("rst_dma_rdata", dma_rdata, 32'd0);
    check("rst_stall_lo", {31'd0, cpu_stall}, 32'd0);
    cpu_req = 1'b1; #1;
    check("rst_stall_follows_req", {31'd0, cpu_stall}, 32'd1);
    cpu_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    // CPU read with wait states
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
    e = '{1'b0, 1'b0, 32'h10, 32'hDEADBEEF}; sb_q.push_back(e);
    wait_ack(8, lat);
    check("rd_latency", 32'(lat), 32'(WS + 1));
    check("rd_stall_c0", {31'd0, stall_hist[0]}, 32'd1);
    check("rd_stall_c1", {31'd0, stall_hist[1]}, 32'd1);
    check("rd_stall_ack", {31'd0, stall_hist[WS + 1]}, 32'd0);
    @(posedge clk); #1; cpu_req = 1'b0;

    // CPU write then read-back
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h20; cpu_wdata = 32'h12345678;
    e = '{1'b0, 1'b1, 32'h20, 32'h12345678}; sb_q.push_back(e);
    wait_ack(8, lat);
    @(posedge clk); #1; cpu_req = 1'b0;
    check("wr_mem_word", mem[8], 32'h12345678);
    check("wr_dma_rdata_unchanged", dma_rdata, 32'd0);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_wdata = 32'd0;
    e = '{1'b0, 1'b0, 32'h20, 32'h12345678}; sb_q.push_back(e);
    wait_ack(8, lat);
    @(posedge clk); #1; cpu_req = 1'b0;
    @(negedge clk);
    check("hold_cpu_rdata", cpu_rdata, 32'h12345678);
    check("idle_mem_addr_hold", mem_addr, 32'h20);

    // Both requesting continuously: starvation escape every third grant
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h44;
    for (int i = 0; i < 6; i++) begin
      if (i % 3 == 2) e = '{1'b1, 1'b0, 32'h44, 32'hB4B4B4B4};
      else e = '{1'b0, 1'b0, 32'h40, 32'hA0A0A0A0};
      sb_q.push_back(e);
    end
    for (int i = 0; i < 6; i++) begin
      wait_ack(8, lat);
      check("arb_occupancy", 32'(lat), 32'(WS + 1));
      if (i % 3 == 2) check("starve_cleared", {28'd0, dut.starve_q}, 32'd0);
    end
    @(posedge clk); #1; cpu_req = 1'b0; dma_req = 1'b0;

    // CPU arrives while DMA owns memory
    @(posedge clk); #1;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h50;
    e = '{1'b1, 1'b0, 32'h50, 32'h55AA55AA}; sb_q.push_back(e);
    @(negedge clk);
    check("dma_own_stall_pre", {31'd0, cpu_stall}, 32'd0);
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
    e = '{1'b0, 1'b0, 32'h10, 32'hDEADBEEF}; sb_q.push_back(e);
    wait_ack(8, lat);
    check("dma_ack_latency", 32'(lat), 32'(WS));
    check("cpu_stall_during_dma", {31'd0, stall_hist[0]}, 32'd1);
    @(posedge clk); #1; dma_req = 1'b0;
    wait_ack(8, lat);
    check("cpu_after_dma_latency", 32'(lat), 32'(WS + 1));
    check("cpu_stall_wait0", {31'd0, stall_hist[0]}, 32'd1);
    check("cpu_stall_ack", {31'd0, stall_hist[WS + 1]}, 32'd0);
    @(posedge clk); #1; cpu_req = 1'b0;

    // DMA write whose request drops (and inputs change) mid-access
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h60; dma_wdata = 32'hCAFEF00D;
    e = '{1'b1, 1'b1, 32'h60, 32'hCAFEF00D}; sb_q.push_back(e);
    @(negedge clk);
    @(posedge clk); #1;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = 32'h64; dma_wdata = 32'd0;
    wait_ack(8, lat);
    check("drop_ack_latency", 32'(lat), 32'(WS));
    @(posedge clk); #1;
    check("drop_mem_word", mem[24], 32'hCAFEF00D);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle_no_ack", {30'd0, cpu_ack, dma_ack}, 32'd0);
      check("idle_no_we", {31'd0, mem_we}, 32'd0);
      check("idle_addr_hold", mem_addr, 32'h60);
    end
    check("drop_dma_rdata_hold", dma_rdata, 32'h55AA55AA);

    // Reset during a CPU write access
    @(posedge clk); #1;
    base = we_pulses;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h70; cpu_wdata = 32'h0BADC0DE;
    @(negedge clk);
    @(posedge clk); #2;
    rst = 1'b0; #1;
    check("mid_rst_cpu_ack", {31'd0, cpu_ack}, 32'd0);
    check("mid_rst_dma_ack", {31'd0, dma_ack}, 32'd0);
    check("mid_rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("mid_rst_mem_addr", mem_addr, 32'd0);
    check("mid_rst_mem_wdata", mem_wdata, 32'd0);
    check("mid_rst_cpu_rdata", cpu_rdata, 32'd0);
    check("mid_rst_dma_rdata", dma_rdata, 32'd0);
    check("mid_rst_stall", {31'd0, cpu_stall}, 32'd1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("mid_rst_no_we", {31'd0, mem_we}, 32'd0);
    end
    check("mid_rst_no_write", 32'(we_pulses - base), 32'd0);
    check("mid_rst_word_kept", mem[28], 32'h11111111);
    rst = 1'b1;
    e = '{1'b0, 1'b1, 32'h70, 32'h0BADC0DE}; sb_q.push_back(e);
    wait_ack(8, lat);
    check("rerequest_latency", 32'(lat), 32'(WS));
    @(posedge clk); #1; cpu_req = 1'b0;
    check("rerequest_word", mem[28], 32'h0BADC0DE);
    check("rerequest_one_write", 32'(we_pulses - base), 32'd1);

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
